arb_cycle_extract: RTL
======================

// Module: arb_cycle_extract
// PURPOSE
//  Downstream of the Bellman-Ford relaxation engine. On start it runs one extra relaxation scan over adjmat/vertmat.
//  A still-relaxable edge means a negative (arbitrage) cycle exists.
//  The block then walks the predecessor chain into that cycle and streams the cycle's vertices to the order-generation stage.
// PARAMETERS
//  NODES     4   vertex count; indices 0..NODES-1
//  PRED_W    3   predecessor field width (bits)
//  WEIGHT_W  24  signed weight field width (bits)
//  WORD_W    27  PRED_W+WEIGHT_W; vertmat word = {pred, weight}
// PORTS
//  clk        in   1                     clock
//  reset      in   1                     asynchronous, active-low reset
//  start      in   1                     pulse; begin extraction (tie to relaxation engine done rise)
//  adjmat     in   [NODES][NODES]x WEIGHT_W  signed edge weights; 0 = no edge
//  vertmat    in   [NODES]x WORD_W       {pred, weight}, stable from start to done
//  busy       out  1                     extraction in progress
//  done       out  1                     level; set at finish, cleared on next accepted start
//  found      out  1                     negative cycle found (valid while done)
//  err        out  1                     pred index >= NODES met during walk/emit
//  cyc_len    out  PRED_W+1              vertices in cycle (valid while done & found)
//  out_valid  out  1                     cycle-vertex stream valid
//  out_ready  in   1                     consumer ready
//  out_vertex out  PRED_W                vertex index
//  out_last   out  1                     final vertex of cycle
// BEHAVIOUR
//  Reset (async, reset==0): state=IDLE; busy, done, found, err, cyc_len, out_valid, out_vertex, out_last all 0.
//    Takes effect mid-operation too; no residual stream beat.
//  INF = {1'b0,{WEIGHT_W-1{1'b1}}} marks an unreached vertex; a source with weight INF is never relaxed from.
//  Sum = sext(w[i]) + sext(e), computed in WEIGHT_W+1 bits signed.
//    Relaxable iff e!=0 && w[i]!=INF && sum < sext(w[j]).
//  States:
//    IDLE: on start, go to SCAN with i=j=0, busy=1, done=0, found=0, err=0. start while busy is ignored.
//    SCAN: one edge (i,j) per cycle in row-major order.
//      - First relaxable edge: witness v=j, go to WALK.
//      - After (NODES-1,NODES-1) with no hit: go to FIN with found=0. No-cycle latency = NODES^2+1 cycles start->done.
//    WALK: v=pred[v], exactly NODES times (one per cycle), so v lies on the cycle. Then head=v, go to EMIT.
//    EMIT: out_vertex=v, out_valid=1.
//      - Beat transfers when out_valid&&out_ready. On transfer: v=pred[v], cyc_len++.
//      - out_last=1 when pred[v]==head.
//      - Last transfer: found=1, go to FIN.
//      - out_vertex/out_last held stable while out_valid&&!out_ready.
//      - Order emitted = predecessor order (reverse of trade direction).
//    FIN: busy=0, done=1, out_valid=0. Go to IDLE.
//  Any pred >= NODES read in WALK/EMIT: err=1, found=0, out_valid=0, go to FIN immediately.
//    Beats already transferred stand.
//  Simultaneous start and FIN in one cycle: start is ignored.
//  cyc_len saturates at NODES. Reaching NODES without returning to head is impossible after WALK.
// STRUCTURE
//  Shared package hft_pkg holds:
//    - NODES, PRED_W, WEIGHT_W, WORD_W
//    - INF constant
//    - vert_word_t packed struct {pred, weight}
//    - arb_state_t enum {IDLE, SCAN, WALK, EMIT, FIN}
//  Single flat module, no sub-module. The relaxable-edge comparator is a function in hft_pkg, shared with the relaxation engine.
// TESTING (NODES=4)
//  - No cycle: edges 0->1=5, 1->2=3; w={0,5,8,INF}; start -> done after 17 cycles; found=0; out_valid never 1.
//  - 3-cycle:
//      edges 0->1=-1, 1->2=-1, 2->0=-1; w={-3,-4,-5,INF}; pred={2,0,1,0}.
//      Witness 0, WALK ends at v=2.
//      Stream 2,1,0 with out_last on 0; found=1, cyc_len=3.
//  - Backpressure: same as the 3-cycle case, out_ready=0 for 3 cycles on beat 2 -> out_vertex=1 held stable; total 3 beats, no loss/dup.
//  - Self-loop: adj[0][0]=-2, w0=0, pred0=0; all else no edge -> single beat 0, out_last=1, cyc_len=1.
//  - Bad pred: 3-cycle case with pred[1]=5 -> err=1, found=0, done=1, stream stops.
//  - Reset mid-EMIT: reset low after beat 1 -> all outputs 0 immediately.
//    Release, then start again -> full 2,1,0 stream.

Source files
------------

// File: rtl/hft_pkg.sv
// Shared types and constants for the arbitrage datapath, plus the edge-relaxation
// predicate shared with the Bellman-Ford relaxation engine.
package hft_pkg;

  localparam int NODES    = 4;
  localparam int PRED_W   = 3;
  localparam int WEIGHT_W = 24;
  localparam int WORD_W   = PRED_W + WEIGHT_W;
  localparam int IDX_W    = $clog2(NODES);

  // Largest positive weight marks a vertex the relaxation never reached
  localparam logic [WEIGHT_W-1:0] INF = {1'b0, {(WEIGHT_W-1){1'b1}}};

  typedef struct packed {
    logic [PRED_W-1:0]   pred;
    logic [WEIGHT_W-1:0] weight;
  } vert_word_t;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    WALK,
    EMIT,
    FIN
  } arb_state_t;

  // One extra bit on the sum so two large negatives cannot wrap positive
  function automatic logic edge_relaxable(input logic [WEIGHT_W-1:0] w_src,
                                          input logic [WEIGHT_W-1:0] e,
                                          input logic [WEIGHT_W-1:0] w_dst);
    logic signed [WEIGHT_W:0] sum;
    sum = $signed({w_src[WEIGHT_W-1], w_src}) + $signed({e[WEIGHT_W-1], e});
    return (e != '0) && (w_src != INF) &&
           (sum < $signed({w_dst[WEIGHT_W-1], w_dst}));
  endfunction

endpackage

// File: rtl/arb_cycle_extract.sv
// Detects a negative cycle with one extra relaxation scan, walks the predecessor
// chain onto the cycle and streams its vertices in predecessor order.
//   state | meaning
//   IDLE  | waiting for start; done/found/err hold last result
//   SCAN  | one edge per cycle, row-major, looking for a relaxable edge
//   WALK  | NODES predecessor hops so the pointer lands on the cycle
//   EMIT  | stream cycle vertices until the chain returns to head
//   FIN   | publish done, drop busy
module arb_cycle_extract
  import hft_pkg::*;
(
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     start,
  input  logic [NODES-1:0][NODES-1:0][WEIGHT_W-1:0] adjmat,
  input  vert_word_t [NODES-1:0]                   vertmat,
  output logic                                     busy,
  output logic                                     done,
  output logic                                     found,
  output logic                                     err,
  output logic [PRED_W:0]                          cyc_len,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [PRED_W-1:0]                        out_vertex,
  output logic                                     out_last
);

  localparam logic [PRED_W-1:0]  NODES_P   = PRED_W'(NODES);
  localparam logic [PRED_W:0]    CYC_MAX   = (PRED_W+1)'(NODES);
  localparam logic [IDX_W-1:0]   WALK_INIT = IDX_W'(NODES-1);
  localparam logic [2*IDX_W-1:0] SCAN_LAST = {IDX_W'(NODES-1), IDX_W'(NODES-1)};

  arb_state_t           state_q, state_d;
  logic [2*IDX_W-1:0]   scan_q, scan_d;
  logic [PRED_W-1:0]    v_q, v_d;
  logic [PRED_W-1:0]    head_q, head_d;
  logic [IDX_W-1:0]     walk_q, walk_d;
  logic [PRED_W:0]      cyc_len_q, cyc_len_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 found_q, found_d;
  logic                 err_q, err_d;

  logic [IDX_W-1:0]     scan_i, scan_j;
  logic [PRED_W-1:0]    cur_pred;
  logic                 bad_pred;

  assign scan_i   = scan_q[2*IDX_W-1:IDX_W];
  assign scan_j   = scan_q[IDX_W-1:0];
  // v_q only ever holds a checked index, so its low bits address vertmat safely
  assign cur_pred = vertmat[v_q[IDX_W-1:0]].pred;
  assign bad_pred = (cur_pred >= NODES_P);

  always_comb begin
    state_d    = state_q;
    scan_d     = scan_q;
    v_d        = v_q;
    head_d     = head_q;
    walk_d     = walk_q;
    cyc_len_d  = cyc_len_q;
    busy_d     = busy_q;
    done_d     = done_q;
    found_d    = found_q;
    err_d      = err_q;
    out_valid  = 1'b0;
    out_vertex = '0;
    out_last   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SCAN;
          scan_d    = '0;
          cyc_len_d = '0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          found_d   = 1'b0;
          err_d     = 1'b0;
        end
      end
      SCAN: begin
        if (edge_relaxable(vertmat[scan_i].weight, adjmat[scan_i][scan_j],
                           vertmat[scan_j].weight)) begin
          v_d     = PRED_W'(scan_j);
          walk_d  = WALK_INIT;
          state_d = WALK;
        end else if (scan_q == SCAN_LAST) begin
          state_d = FIN;
        end else begin
          scan_d = scan_q + (2*IDX_W)'(1);
        end
      end
      WALK: begin
        if (bad_pred) begin
          err_d   = 1'b1;
          found_d = 1'b0;
          state_d = FIN;
        end else begin
          v_d = cur_pred;
          if (walk_q == '0) begin
            head_d  = cur_pred;
            state_d = EMIT;
          end else begin
            walk_d = walk_q - IDX_W'(1);
          end
        end
      end
      EMIT: begin
        if (bad_pred) begin
          err_d   = 1'b1;
          found_d = 1'b0;
          state_d = FIN;
        end else begin
          out_valid  = 1'b1;
          out_vertex = v_q;
          out_last   = (cur_pred == head_q);
          if (out_ready) begin
            v_d = cur_pred;
            if (cyc_len_q != CYC_MAX) cyc_len_d = cyc_len_q + (PRED_W+1)'(1);
            if (out_last) begin
              found_d = 1'b1;
              state_d = FIN;
            end
          end
        end
      end
      FIN: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      scan_q    <= '0;
      v_q       <= '0;
      head_q    <= '0;
      walk_q    <= '0;
      cyc_len_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      found_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      scan_q    <= scan_d;
      v_q       <= v_d;
      head_q    <= head_d;
      walk_q    <= walk_d;
      cyc_len_q <= cyc_len_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      found_q   <= found_d;
      err_q     <= err_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign found   = found_q;
  assign err     = err_q;
  assign cyc_len = cyc_len_q;

endmodule
